// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory read port plus the valid/ready queue
// head presented to decode.
interface fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  modport master (
    output imem_addr,
    input  imem_data,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads imem, buffers {instr, pc} in a small queue.
// Optional FETCH_MISALIGN_CHECK_EN halts on misaligned redirect targets.
//
//   state  | meaning
//   BOOT   | one idle cycle after reset release
//   RUN    | fetching, one push per cycle when queue has room
//   HALTED | no fetching; queue drains; only a redirect leaves
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          QDEPTH     = 2,
  parameter int          IMEM_BYTES = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_unit_if.master      fif,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              halt_req,
  output logic [31:0]       fetch_pc,
  output logic              misalign_err
);

  localparam int          PW        = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int          CW        = $clog2(QDEPTH) + 1;
  localparam logic [31:0] ADDR_MASK = 32'(IMEM_BYTES - 1);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [31:0]     pc;
  logic [CW-1:0]   count;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [31:0]     instr_q [QDEPTH];
  logic [31:0]     pc_q    [QDEPTH];

  logic            head_take;
  logic            push, pop, redir;
  logic [31:0]     redir_target;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic            misalign;
`endif

  assign fif.imem_addr = pc & ADDR_MASK;
  assign fif.out_valid = (count != '0);
  assign fif.out_instr = instr_q[rd_ptr];
  assign fif.out_pc    = pc_q[rd_ptr];
  assign fetch_pc      = pc;
  assign head_take     = fif.out_valid && fif.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    push         = 1'b0;
    redir        = 1'b0;
    redir_target = {redirect_pc[31:2], 2'b00};
`ifdef FETCH_MISALIGN_CHECK_EN
    misalign     = 1'b0;
    redir_target = redirect_pc;
`endif
    case (state)
      BOOT: state_nx = RUN;
      RUN: begin
        if (redirect_valid) begin
          redir    = 1'b1;
          state_nx = RUN;
        end else if (halt_req) begin
          state_nx = HALTED;
        end else begin
          // a same-cycle pop frees the slot being written
          push = (count < CW'(QDEPTH)) || head_take;
        end
      end
      HALTED: begin
        if (redirect_valid) begin
          redir    = 1'b1;
          state_nx = RUN;
        end
      end
      default: state_nx = BOOT;
    endcase
`ifdef FETCH_MISALIGN_CHECK_EN
    if (redir && (redirect_pc[1:0] != 2'b00)) begin
      misalign = 1'b1;
      state_nx = HALTED;
    end
`endif
    pop = head_take && !redir;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else if (redir) begin
      pc     <= redir_target;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        instr_q[wr_ptr] <= fif.imem_data;
        pc_q[wr_ptr]    <= pc;
        wr_ptr          <= wr_ptr + 1'b1;
        pc              <= pc + 32'd4;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        misalign_err <= 1'b0;
    else if (misalign) misalign_err <= 1'b1;
  end
`else
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign misalign_err         = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming with address wrap, backpressure,
// redirect flush, halt/resume, redirect+halt, misaligned redirect, async reset.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt_req = 1'b0;
  logic [31:0] fetch_pc;
  logic        misalign_err;
  int          checks = 0;
  int          errors = 0;

  fetch_unit_if fif();

  fetch_unit #(.RESET_PC(32'h0), .QDEPTH(2), .IMEM_BYTES(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fif            (fif),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .fetch_pc       (fetch_pc),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  // Word at byte address a is C0DE_0000 | (a/4); index bits beyond the
  // 32-byte memory expose a missing address wrap.
  assign fif.imem_data = 32'hC0DE_0000 | {25'b0, fif.imem_addr[8:2]};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    fif.out_ready = 1'b1;
    #3;
    chk1 ("rst_valid", fif.out_valid, 1'b0);
    chk32("rst_instr", fif.out_instr, 32'h0);
    chk32("rst_outpc", fif.out_pc, 32'h0);
    chk32("rst_addr", fif.imem_addr, 32'h0);
    chk32("rst_fetchpc", fetch_pc, 32'h0);
    chk1 ("rst_err", misalign_err, 1'b0);

    // Reset and streaming with address wrap
    do_reset();
    tick();
    chk1 ("boot_valid", fif.out_valid, 1'b0);
    chk32("boot_fetchpc", fetch_pc, 32'h0);
    tick();
    for (int i = 0; i < 9; i++) begin
      chk1 ("str_valid", fif.out_valid, 1'b1);
      chk32("str_outpc", fif.out_pc, 32'(4 * i));
      chk32("str_instr", fif.out_instr, 32'hC0DE_0000 | 32'(i % 8));
      chk32("str_addr", fif.imem_addr, 32'((4 * (i + 1)) % 32));
      tick();
    end

    // Backpressure
    fif.out_ready = 1'b0;
    do_reset();
    tick();
    tick();
    chk32("bp_outpc0", fif.out_pc, 32'h0);
    chk32("bp_fetchpc1", fetch_pc, 32'h4);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk32("bp_stall_fetchpc", fetch_pc, 32'h8);
      chk32("bp_hold_outpc", fif.out_pc, 32'h0);
      chk32("bp_hold_instr", fif.out_instr, 32'hC0DE_0000);
    end
    fif.out_ready = 1'b1;
    tick();
    chk32("bp_rel_outpc4", fif.out_pc, 32'h4);
    chk32("bp_rel_fetchpc", fetch_pc, 32'hC);
    tick();
    chk32("bp_rel_outpc8", fif.out_pc, 32'h8);
    chk32("bp_rel_instr8", fif.out_instr, 32'hC0DE_0002);

    // Redirect flush with a full queue
    fif.out_ready = 1'b0;
    do_reset();
    tick();
    tick();
    tick();
    chk32("rf_full_fetchpc", fetch_pc, 32'h8);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    tick();
    redirect_valid = 1'b0;
    chk1 ("rf_bubble", fif.out_valid, 1'b0);
    chk32("rf_fetchpc", fetch_pc, 32'h10);
    tick();
    chk1 ("rf_valid", fif.out_valid, 1'b1);
    chk32("rf_outpc16", fif.out_pc, 32'h10);
    chk32("rf_instr16", fif.out_instr, 32'hC0DE_0004);
    fif.out_ready = 1'b1;
    tick();
    chk32("rf_outpc20", fif.out_pc, 32'h14);
    chk32("rf_instr20", fif.out_instr, 32'hC0DE_0005);

    // Halt then resume
    do_reset();
    tick();
    tick();
    tick();
    tick();
    chk32("h_fetchpc12", fetch_pc, 32'hC);
    chk32("h_outpc8", fif.out_pc, 32'h8);
    halt_req      = 1'b1;
    fif.out_ready = 1'b0;
    tick();
    halt_req = 1'b0;
    chk32("h_nopush", fetch_pc, 32'hC);
    tick();
    tick();
    chk1 ("h_queued_valid", fif.out_valid, 1'b1);
    chk32("h_queued_pc", fif.out_pc, 32'h8);
    chk32("h_stalled", fetch_pc, 32'hC);
    fif.out_ready = 1'b1;
    tick();
    chk1 ("h_drained", fif.out_valid, 1'b0);
    tick();
    tick();
    tick();
    chk1 ("h_stays_empty", fif.out_valid, 1'b0);
    chk32("h_fetchpc_hold", fetch_pc, 32'hC);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h4;
    tick();
    redirect_valid = 1'b0;
    chk1 ("h_redir_bubble", fif.out_valid, 1'b0);
    tick();
    chk1 ("h_resume_valid", fif.out_valid, 1'b1);
    chk32("h_resume_pc", fif.out_pc, 32'h4);
    chk32("h_resume_instr", fif.out_instr, 32'hC0DE_0001);

    // Simultaneous redirect and halt: redirect wins, stays in RUN
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8;
    halt_req       = 1'b1;
    tick();
    redirect_valid = 1'b0;
    halt_req       = 1'b0;
    chk1 ("rh_bubble", fif.out_valid, 1'b0);
    chk32("rh_fetchpc", fetch_pc, 32'h8);
    tick();
    chk32("rh_outpc8", fif.out_pc, 32'h8);
    chk32("rh_instr8", fif.out_instr, 32'hC0DE_0002);
    tick();
    chk32("rh_outpc12", fif.out_pc, 32'hC);
    chk1 ("rh_valid12", fif.out_valid, 1'b1);

    // Misaligned redirect
    redirect_valid = 1'b1;
    redirect_pc    = 32'h6;
    tick();
    redirect_valid = 1'b0;
    chk1 ("ma_bubble", fif.out_valid, 1'b0);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk32("ma_fetchpc", fetch_pc, 32'h6);
    chk1 ("ma_err", misalign_err, 1'b1);
    tick();
    tick();
    chk1 ("ma_nopush", fif.out_valid, 1'b0);
    chk32("ma_fetchpc_hold", fetch_pc, 32'h6);
    chk1 ("ma_err_sticky", misalign_err, 1'b1);
`else
    chk32("ma_fetchpc", fetch_pc, 32'h4);
    chk1 ("ma_err", misalign_err, 1'b0);
    tick();
    chk32("ma_outpc4", fif.out_pc, 32'h4);
    tick();
    chk32("ma_outpc8", fif.out_pc, 32'h8);
    chk1 ("ma_err_zero", misalign_err, 1'b0);
`endif

    // Asynchronous reset mid-operation
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk1 ("arst_valid", fif.out_valid, 1'b0);
    chk32("arst_fetchpc", fetch_pc, 32'h0);
    chk32("arst_outpc", fif.out_pc, 32'h0);
    chk32("arst_instr", fif.out_instr, 32'h0);
    chk1 ("arst_err", misalign_err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the instruction memory and downstream-facing toward decode. Owns the program counter, drives the memory's word address, captures the returned 32-bit instruction together with its PC into a small fetch queue, and presents queue entries to decode over a valid/ready handshake. Supports branch/jump redirect with queue flush, and a halt request.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.
- `QDEPTH`, 2: fetch queue entries; power of 2, at least 2.
- `IMEM_BYTES`, 32: instruction memory size in bytes; power of 2, at least 4.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_addr`  out  32  byte address to the instruction memory: `pc mod IMEM_BYTES`, with the upper bits zero.
- `imem_data`  in  32  instruction read combinationally at `imem_addr`.
- `redirect_valid`  in  1  taken branch/jump from execute.
- `redirect_pc`  in  32  redirect target.
- `halt_req`  in  1  stop fetching, e.g. on ecall/ebreak.
- `out_valid`  out  1  queue head valid.
- `out_ready`  in  1  decode accepts head.
- `out_instr`  out  32  head instruction.
- `out_pc`  out  32  head PC (full 32-bit, unwrapped).
- `fetch_pc`  out  32  current PC register.
- `misalign_err`  out  1  sticky misaligned-redirect flag. Tied 0 without the macro.

## Operation
- **State machine.** States are BOOT, RUN and HALTED.
  - Reset enters BOOT.
  - BOOT lasts exactly one cycle after reset release, makes no push, and then moves to RUN.
  - RUN moves to HALTED on `halt_req`. The PC is not advanced and no push occurs in that cycle.
  - HALTED makes no pushes. The queue keeps draining to decode. `halt_req` is ignored while in HALTED.
  - `redirect_valid` in any state other than BOOT moves to RUN.
  - `redirect_valid` has priority over `halt_req` when both are asserted.
- **Push.** In RUN with no redirect and no halt, push `{imem_data, pc}` when count < QDEPTH, or when a pop happens in the same cycle. On a push, `pc <= pc + 4`, modulo 2^32.
- **Pop.** A pop occurs when `out_valid && out_ready`.
- **Simultaneous push and pop.** Count is unchanged. This holds when the queue is full as well.
- **Redirect.** Clears all queue entries (count = 0, pointers reset). Loads `pc <= redirect_pc`. No push and no pop take effect that cycle.
- **Memory address wrap.** `imem_addr` wraps: PC = IMEM_BYTES−4 is followed by address 0. `out_pc` and `fetch_pc` keep counting upward.
- **Queue head outputs.** `out_instr` and `out_pc` are driven directly from queue head storage. They hold their value while `out_valid && !out_ready`.
- **Reset values.**
  - pc = RESET_PC, state = BOOT, count = 0, `misalign_err` = 0.
  - `out_valid` = 0, `out_instr` = 0, `out_pc` = 0.
  - `imem_addr` = RESET_PC mod IMEM_BYTES.
- **Reset mid-operation.** Takes effect immediately and asynchronously. All queue contents are discarded.

## Timing
- **After reset release** (edge E0 is the first edge with `rst_n` high):
  - E0 leaves BOOT.
  - E1 makes the first push.
  - `out_valid` is high from E1 onward, carrying `out_pc` = RESET_PC.
- **Fetch latency.** One cycle from `imem_addr` to the entry being visible at `out_*`.
- **Redirect latency.** With the redirect sampled at edge N:
  - `out_valid` = 0 after N.
  - The target is pushed at N+1.
  - The target is visible at `out_*` after N+1.
- **Throughput.** Steady state is one instruction per cycle while `out_ready` = 1.
- **Halt.** `halt_req` sampled at edge N means no push at N or afterwards. Entries already queued remain poppable.

## Configuration
- **Macro:** `FETCH_MISALIGN_CHECK_EN`.
- **Defined:**
  - Trigger: `redirect_valid` with `redirect_pc[1:0] != 0`.
  - The redirect still flushes the queue and loads pc.
  - State goes to HALTED instead of RUN.
  - `misalign_err` sets and stays set until reset.
- **Undefined:**
  - The redirect loads `{redirect_pc[31:2], 2'b00}`.
  - State goes to RUN.
  - `misalign_err` stays 0.

## Test plan
- **Reset and streaming.** Memory preloaded with words W0..W7, `out_ready` = 1. Expect `out_pc` sequence 0,4,8,…,28 with `out_instr` W0..W7. Then `out_pc` = 32 with `out_instr` = W0 (address wrap). No bubbles after the first valid.
- **Backpressure.** `out_ready` = 0 for 5 cycles. Expect count to saturate at 2, `fetch_pc` to stall at 8, and `out_pc` to hold at 0. Releasing `out_ready` resumes 0,4,8 with no loss or duplication.
- **Redirect flush.** Queue full (0,4), then `redirect_valid` with `redirect_pc` = 16. Expect `out_valid` = 0 for one cycle, then `out_pc` = 16, 20. Entries 0 and 4 are never accepted after the redirect.
- **Halt then resume.** `halt_req` asserted at `fetch_pc` = 12. Expect the queued entries to drain, then `out_valid` = 0 indefinitely. `redirect_pc` = 4 then resumes with `out_pc` = 4.
- **Simultaneous redirect and halt.** Both asserted in the same cycle with target 8. Expect state RUN and `out_pc` = 8 to follow.
- **Misaligned redirect.** `redirect_pc` = 6.
  - With the macro: HALTED, `misalign_err` = 1, no further pushes.
  - Without: `out_pc` = 4 then 8, `misalign_err` = 0.
